stack_queue: RTL and testbench

Parametrised LIFO/FIFO buffer, the next generation of the team's `stack` block, for the labelling and flood-fill path, where pixel coordinates are pushed and popped during region growing. Occupancy is counted correctly for any DEPTH. Read data is registered with an explicit valid strobe and is not zeroed. Simultaneous push and pop are defined in both modes. A runtime mode input selects LIFO or FIFO order; the mode can only change while the buffer is empty.

---
 rtl/stack_queue_if.sv | 33 +++
 rtl/stack_queue.sv | 159 +++++++++++++++
 tb/tb_stack_queue.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/stack_queue_if.sv
// stack_queue_if: request/response bundle of the stack_queue buffer.
// master drives requests and write data, slave returns data and status.
interface stack_queue_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             flush;
  logic             mode;
  logic             push;
  logic [WIDTH-1:0] d;
  logic             pop;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic [AW:0]      count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, mode, push, d, pop,
    input  q, q_valid, count, empty, full,
    input  overflow, underflow
  );

  modport slave (
    input  flush, mode, push, d, pop,
    output q, q_valid, count, empty, full,
    output overflow, underflow
  );
endinterface

// File: rtl/stack_queue.sv
// stack_queue: LIFO/FIFO buffer with registered read data and valid strobe.
// Define STACK_QUEUE_ERR_EN to build the sticky overflow/underflow flags.
module stack_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input logic        clk,
  input logic        reset,
  stack_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q_valid_q, q_valid_d;
  logic             mode_r_q, mode_r_d;

  logic             empty, full, fifo;
  logic             push_only, pop_only, both;
  logic [AW-1:0]    top, wr_base, rd_base;
  logic             we;
  logic [AW-1:0]    waddr;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (count_q == '0);
  assign full      = (count_q == (AW+1)'(DEPTH));
  assign fifo      = empty ? bus.mode : mode_r_q;
  assign push_only = bus.push & ~bus.pop;
  assign pop_only  = bus.pop & ~bus.push;
  assign both      = bus.push & bus.pop;
  // wraps to DEPTH-1 when count == DEPTH is a power of two
  assign top       = count_q[AW-1:0] - 1'b1;
  // an empty buffer always restarts its FIFO pointers at 0
  assign wr_base   = empty ? '0 : wr_ptr_q;
  assign rd_base   = empty ? '0 : rd_ptr_q;

  // next-state for occupancy, pointers, read data and memory write
  always_comb begin
    count_d   = count_q;
    wr_ptr_d  = wr_base;
    rd_ptr_d  = rd_base;
    q_d       = q_q;
    q_valid_d = 1'b0;
    mode_r_d  = fifo;
    we        = 1'b0;
    waddr     = '0;
    if (bus.flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else if (both) begin
      q_valid_d = 1'b1;
      if (empty) begin
        q_d = bus.d;
      end else if (fifo) begin
        q_d      = mem_q[rd_base];
        we       = 1'b1;
        waddr    = wr_base;
        wr_ptr_d = inc(wr_base);
        rd_ptr_d = inc(rd_base);
      end else begin
        q_d   = mem_q[top];
        we    = 1'b1;
        waddr = top;
      end
    end else if (push_only && !full) begin
      we      = 1'b1;
      count_d = count_q + 1'b1;
      if (fifo) begin
        waddr    = wr_base;
        wr_ptr_d = inc(wr_base);
      end else begin
        waddr = count_q[AW-1:0];
      end
    end else if (pop_only && !empty) begin
      q_valid_d = 1'b1;
      count_d   = count_q - 1'b1;
      if (fifo) begin
        q_d      = mem_q[rd_base];
        rd_ptr_d = inc(rd_base);
      end else begin
        q_d = mem_q[top];
      end
    end
    if (!fifo) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  // control and read-data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      mode_r_q  <= 1'b0;
    end else begin
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      mode_r_q  <= mode_r_d;
    end
  end

  // storage array, never reset; reset still blocks writes
  always_ff @(posedge clk) begin
    if (!reset && we) begin
      mem_q[waddr] <= bus.d;
    end
  end

`ifdef STACK_QUEUE_ERR_EN
  logic ovf_q, ovf_d, unf_q, unf_d;

  // sticky error flags, cleared only by reset
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (!bus.flush) begin
      if (push_only && full) ovf_d = 1'b1;
      if (pop_only && empty) unf_d = 1'b1;
    end
  end

  // error flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

  assign bus.q       = q_q;
  assign bus.q_valid = q_valid_q;
  assign bus.count   = count_q;
  assign bus.empty   = empty;
  assign bus.full    = full;
endmodule

// File: tb/tb_stack_queue.sv
// tb_stack_queue: directed vector bench for stack_queue.
// Covers LIFO/FIFO order, wrap, bypass, errors, mode, flush and reset.
module tb_stack_queue;
  logic clk = 1'b0;
  logic rst8 = 1'b1;
  logic rst5 = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

`ifdef STACK_QUEUE_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  always #5 clk = ~clk;

  stack_queue_if #(.WIDTH(32), .DEPTH(8)) b8 ();
  stack_queue_if #(.WIDTH(32), .DEPTH(5)) b5 ();

  stack_queue #(.WIDTH(32), .DEPTH(8)) u8 (
    .clk(clk), .reset(rst8), .bus(b8.slave)
  );
  stack_queue #(.WIDTH(32), .DEPTH(5)) u5 (
    .clk(clk), .reset(rst5), .bus(b5.slave)
  );

  typedef struct {
    logic        push;
    logic        pop;
    logic        mode;
    logic        flush;
    logic [31:0] d;
    logic        ev;
    logic [31:0] eq;
    int          ec;
    logic        cq;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic pu, po, input logic [31:0] dd,
    input logic ev, input logic [31:0] eq,
    input int ec, input logic cq
  );
    vec_t v;
    v.push = pu; v.pop = po; v.mode = 1'b0; v.flush = 1'b0;
    v.d = dd; v.ev = ev; v.eq = eq; v.ec = ec; v.cq = cq;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic s8(input logic pu, po, mo, fl, input logic [31:0] dd);
    b8.push = pu; b8.pop = po; b8.mode = mo;
    b8.flush = fl; b8.d = dd;
    @(posedge clk); #1;
  endtask

  task automatic s5(input logic pu, po, input logic [31:0] dd);
    b5.push = pu; b5.pop = po; b5.mode = 1'b1;
    b5.flush = 1'b0; b5.d = dd;
    @(posedge clk); #1;
  endtask

  task automatic st8(input string nm, input int ec);
    chk({nm, ".count"}, 32'(b8.count), 32'(ec));
    chk({nm, ".empty"}, 32'(b8.empty), 32'(ec == 0));
    chk({nm, ".full"}, 32'(b8.full), 32'(ec == 8));
  endtask

  initial begin
    b8.push = 0; b8.pop = 0; b8.mode = 0; b8.flush = 0; b8.d = '0;
    b5.push = 0; b5.pop = 0; b5.mode = 1; b5.flush = 0; b5.d = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.q", b8.q, 32'h0);
    chk("rst.qv", 32'(b8.q_valid), 32'h0);
    st8("rst", 0);
    chk("rst.ovf", 32'(b8.overflow), 32'h0);
    chk("rst.unf", 32'(b8.underflow), 32'h0);
    chk("rst5.count", 32'(b5.count), 32'h0);
    rst8 = 1'b0;
    rst5 = 1'b0;

    for (int i = 1; i <= 8; i++) tbl.push_back(mk(1, 0, i, 0, 0, i, 0));
    for (int i = 8; i >= 1; i--) tbl.push_back(mk(0, 1, 0, 1, i, i - 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 1, 32'hAA, 1, 32'hAA, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 32'hAA, 0, 1));
    for (int i = 1; i <= 8; i++) tbl.push_back(mk(1, 0, i, 0, 0, i, 0));
    tbl.push_back(mk(1, 1, 32'h55, 1, 8, 8, 1));
    tbl.push_back(mk(0, 1, 0, 1, 32'h55, 7, 1));
    tbl.push_back(mk(1, 0, 32'h77, 0, 0, 8, 0));
    tbl.push_back(mk(1, 0, 32'h99, 0, 0, 8, 0));
    tbl.push_back(mk(0, 1, 0, 1, 32'h77, 7, 1));
    tbl.push_back(mk(1, 0, 32'h99, 0, 0, 8, 0));

    foreach (tbl[i]) begin
      s8(tbl[i].push, tbl[i].pop, tbl[i].mode, tbl[i].flush, tbl[i].d);
      chk($sformatf("v%0d.qv", i), 32'(b8.q_valid), 32'(tbl[i].ev));
      st8($sformatf("v%0d", i), tbl[i].ec);
      if (tbl[i].cq) chk($sformatf("v%0d.q", i), b8.q, tbl[i].eq);
    end

    chk("ovf.set", 32'(b8.overflow), 32'(ERR));
    chk("unf.clear", 32'(b8.underflow), 32'h0);
    s8(0, 0, 0, 1, 0);
    st8("flush", 0);
    chk("flush.ovf", 32'(b8.overflow), 32'(ERR));
    s8(0, 1, 0, 0, 0);
    chk("unf.qv", 32'(b8.q_valid), 32'h0);
    chk("unf.q", b8.q, 32'h77);
    chk("unf.set", 32'(b8.underflow), 32'(ERR));
    st8("unf", 0);

    s8(1, 0, 0, 0, 1);
    s8(1, 0, 0, 0, 2);
    s8(1, 0, 0, 0, 3);
    s8(0, 1, 1, 0, 0);
    chk("mode.ign.q", b8.q, 32'h3);
    st8("mode.ign", 2);
    s8(0, 0, 1, 1, 0);
    st8("mode.flush", 0);
    s8(1, 0, 1, 0, 32'h21);
    s8(1, 0, 1, 0, 32'h22);
    s8(0, 1, 1, 0, 0);
    chk("mode.fifo.q", b8.q, 32'h21);
    chk("mode.fifo.qv", 32'(b8.q_valid), 32'h1);
    st8("mode.fifo", 1);

    rst8 = 1'b1;
    s8(1, 0, 1, 0, 32'h5A);
    rst8 = 1'b0;
    chk("rstop.q", b8.q, 32'h0);
    chk("rstop.qv", 32'(b8.q_valid), 32'h0);
    st8("rstop", 0);
    chk("rstop.ovf", 32'(b8.overflow), 32'h0);
    s8(0, 1, 0, 0, 0);
    chk("rstop.pop.qv", 32'(b8.q_valid), 32'h0);

    for (int i = 10; i <= 14; i++) s5(1, 0, i);
    chk("f5.full", 32'(b5.full), 32'h1);
    chk("f5.count", 32'(b5.count), 32'h5);
    for (int i = 10; i <= 11; i++) begin
      s5(0, 1, 0);
      chk($sformatf("f5.pop%0d", i), b5.q, i);
      chk($sformatf("f5.qv%0d", i), 32'(b5.q_valid), 32'h1);
    end
    s5(1, 0, 15);
    s5(1, 0, 16);
    chk("f5.wrap.count", 32'(b5.count), 32'h5);
    for (int i = 12; i <= 16; i++) begin
      s5(0, 1, 0);
      chk($sformatf("f5.pop%0d", i), b5.q, i);
    end
    chk("f5.empty", 32'(b5.empty), 32'h1);
    s5(0, 0, 0);
    chk("f5.qv.end", 32'(b5.q_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
